ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
Shares the single-port word-addressed ram between the RV32I core's instruction-fetch port and its load/store port. It accepts req/ack transactions from both requesters and picks a winner round-robin. It drives the ram's r/w strobes, address and write data, waits the ram read latency, then returns read data with a one-cycle ack. It sits between the core front end / LSU and the ram instance.

Parameters:
ADDR_W, 32, ram word-address width
DATA_W, 32, data width
RD_LAT, 1, number of edges (1..7) between the ram sampling a read strobe and mem_rdata being valid to sample

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held until i_ack
i_addr  in  ADDR_W  fetch word address
i_ack  out  1  one-cycle completion pulse to fetch
i_rdata  out  DATA_W  fetch data, valid while i_ack=1
d_req  in  1  load/store request; held until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  load/store word address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle completion pulse to LSU
d_rdata  out  DATA_W  load data, valid while d_ack=1 and the op was a load
mem_r  out  1  ram read strobe
mem_w  out  1  ram write strobe
mem_addr  out  ADDR_W  ram address
mem_wdata  out  DATA_W  ram write data
mem_rdata  in  DATA_W  ram read data

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; mem_r=0, mem_w=0, mem_addr=0, mem_wdata=0; i_ack=0, d_ack=0, i_rdata=0, d_rdata=0; last_grant=INSTR, so data wins the first contention; wait counter=0.
- All outputs are registered.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: samples requests at each edge.
  - Neither requesting: stay in IDLE.
  - One requesting: grant it.
  - Both requesting: grant the port not in last_grant.
  - On grant: latch winner, addr, we and wdata into mem_*; set mem_r=~we or mem_w=we; update last_grant; go to ACCESS.
  - A fetch grant is always a read.
- ACCESS: the strobe is high for exactly this one cycle, then cleared.
  - Write: go to RESP.
  - Read: load counter with RD_LAT and go to WAIT.
- WAIT: decrement the counter each edge. On the edge where the counter reaches 1:
  - capture mem_rdata into the winner's rdata register;
  - go to RESP.
- RESP: the winner's ack is high for exactly one cycle; go to IDLE. Requests are ignored during RESP.
- Handshake:
  - A requester holds req and its operands stable until it samples ack=1.
  - It may drop req, or present a new request, on the same edge.
  - The arbiter re-samples in IDLE, so back-to-back requests cost one idle-state cycle.
- Latency, counted from the IDLE edge that grants to the edge where ack is first sampled high:
  - write = 2 edges;
  - read = 2+RD_LAT edges (3 for default).
- Throughput: one transaction per 3 cycles (write) or 3+RD_LAT cycles (read).
- The losing requester waits one full transaction. Round-robin bounds its wait to one transaction.
- Invariants:
  - mem_r and mem_w are never both 1.
  - i_ack and d_ack are never both 1.
  - Outside ACCESS, mem_addr and mem_wdata hold their last value.
  - rdata registers hold their value until the next read for that port.
- Store ack: d_rdata is unchanged.
- Request dropped before ack (protocol violation): the transaction still completes and the ack still pulses.
- Reset mid-transaction: the FSM is forced to IDLE immediately, all strobes and acks go to 0, and the in-flight transaction is abandoned without an ack. last_grant returns to INSTR.
- Address wrap: the address passes through unmodified; there is no range checking.

Decomposition:
- Package ram_arb_pkg holds:
  - the state enum IDLE/ACCESS/WAIT/RESP (2-bit);
  - grant ID constants GNT_INSTR=0 and GNT_DATA=1;
  - the RD_LAT counter width constant (3 bits).
- One natural sub-module, rr_pick2: combinational two-way round-robin pick (inputs i_req, d_req, last_grant; outputs valid and winner).
- The FSM, operand mux and rdata registers remain in ram_arbiter.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with i_req=d_req=1 -> mem_r=mem_w=0, both acks 0, all data outputs 0. Release -> d wins first.
- Fetch alone: i_addr=0x10 with the ram preloaded 0x10=0xDEADBEEF, RD_LAT=1 -> mem_r pulses one cycle with mem_addr=0x10; i_ack is high 3 edges after the grant, with i_rdata=0xDEADBEEF.
- Store alone: d_we=1, d_addr=0x4, d_wdata=0x12345678 -> mem_w pulses one cycle; d_ack is at edge 2. A following load of 0x4 returns 0x12345678 with mem_w=0 throughout.
- Contention: i_req and d_req held high for 4 transactions -> grant order is D, I, D, I. Acks never overlap, and no port waits more than one transaction.
- Latency sweep: RD_LAT=3, fetch of 0x20 -> ack at edge 5 after grant, with data sampled on the correct edge (wrong-edge ram data differs).
- Reset mid-read: assert rst_n=0 during WAIT -> no ack, FSM in IDLE. After release, the held request is re-granted and completes normally.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the fetch/LSU ram arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic GNT_INSTR = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  // Wide enough for the largest read latency (7).
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, contention goes to the
// port that was not granted last.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic i_ireq,
  input  logic i_dreq,
  input  logic i_last_grant,
  output logic o_valid,
  output logic o_winner
);

  always_comb begin
    o_valid  = i_ireq | i_dreq;
    o_winner = GNT_INSTR;
    if (i_ireq && i_dreq) begin
      o_winner = (i_last_grant == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
    end else if (i_dreq) begin
      o_winner = GNT_DATA;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port ram between instruction fetch and load/store,
// round-robin on contention, with registered strobes, data and acks.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_r,
  output logic              mem_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  logic             r_last_grant;
  logic             r_winner;
  logic             r_we;
  logic [CNT_W-1:0] r_cnt;

  logic w_valid;
  logic w_winner;

  rr_pick2 u_pick (
    .i_ireq       (i_req),
    .i_dreq       (d_req),
    .i_last_grant (r_last_grant),
    .o_valid      (w_valid),
    .o_winner     (w_winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= GNT_INSTR;
      r_winner     <= GNT_INSTR;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      mem_r        <= 1'b0;
      mem_w        <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i_ack        <= 1'b0;
      d_ack        <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_winner     <= w_winner;
            r_last_grant <= w_winner;
            r_state      <= ACCESS;
            if (w_winner == GNT_DATA) begin
              r_we      <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_r     <= ~d_we;
              mem_w     <= d_we;
            end else begin
              // Fetch has no write data, so mem_wdata keeps its last value.
              r_we     <= 1'b0;
              mem_addr <= i_addr;
              mem_r    <= 1'b1;
              mem_w    <= 1'b0;
            end
          end
        end
        ACCESS: begin
          mem_r <= 1'b0;
          mem_w <= 1'b0;
          if (r_we) begin
            i_ack   <= (r_winner == GNT_INSTR);
            d_ack   <= (r_winner == GNT_DATA);
            r_state <= RESP;
          end else begin
            r_cnt   <= CNT_LOAD;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_ONE;
          // The count of 1 marks the edge on which the ram data is valid.
          if (r_cnt == CNT_ONE) begin
            if (r_winner == GNT_DATA) begin
              d_rdata <= mem_rdata;
            end else begin
              i_rdata <= mem_rdata;
            end
            i_ack   <= (r_winner == GNT_INSTR);
            d_ack   <= (r_winner == GNT_DATA);
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
